mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Memory-stage load/store unit of the 5-stage RV32I pipeline. It sits between the EX/MEM register and the Writeback cycle. It issues requests to a variable-latency data memory over a req/gnt/rvalid handshake and stalls the pipeline while a transaction is outstanding. For loads it extracts and right-aligns the addressed byte or halfword; sign or zero handling of that value is done in Writeback.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in WAIT before the load is aborted with bus error
ADDR_W, 32, data address width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
flush  in  1  kill the current op (branch mispredict / trap)
in_valid  in  1  EX/MEM slot holds a valid instruction
in_memRead  in  1  load
in_memWrite  in  1  store
in_aluSelect  in  6  operation encoding
in_address  in  ADDR_W  effective address (ALU result)
in_storeData  in  32  rs2 value
in_rd  in  5  destination register
in_regWrite  in  1  instruction writes rd
stall  out  1  hold IF..EX/MEM this cycle
dmem_req  out  1  request valid
dmem_we  out  1  1 = write
dmem_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  read data valid
dmem_rdata  in  32  read word
wb_valid  out  1  writeback slot valid
wb_data  out  32  aligned load data or passthrough ALU result
wb_rd  out  5  destination register
wb_regWrite  out  1  rd write enable; forced 0 on any fault
wb_aluSelect  out  6  forwarded for Writeback extension
wb_misaligned  out  1  address misaligned fault
wb_busErr  out  1  load timeout fault

Behaviour:
- Encodings: LB 001011, LH 001100, LW 001101, LBU 001110, LHU 001111, SB 010000, SH 010001, SW 010010.
- Reset: state IDLE. All outputs 0. Timeout counter 0. Discard flag 0.
- FSM states: IDLE, REQ, WAIT.
- IDLE, non-memory op (in_valid and neither read nor write): register passthrough next edge. wb_data = in_address, wb_valid = 1, stall = 0. Latency is 1 cycle.
- IDLE, in_valid = 0: wb_valid = 0 next edge.
- Misalignment: halfword ops with addr[0] = 1, word ops with addr[1:0] != 0.
- IDLE, misaligned memory op: no bus request. Next edge: wb_valid = 1, wb_misaligned = 1, wb_regWrite = 0. No stall.
- IDLE, aligned memory op:
  - stall = 1 combinationally.
  - Latch op, address, rd and lane data, then go to REQ.
  - dmem_be: SB = 1 << a[1:0]; SH = 0011 << a[1:0]; SW = 1111. Loads drive be = 1111.
  - dmem_wdata: byte replicated ×4, half replicated ×2, word as-is.
- REQ:
  - dmem_req = 1. Address, we, be and wdata are held stable until dmem_gnt.
  - gnt on a store: wb_valid = 1 next edge, go to IDLE.
  - gnt on a load: go to WAIT and clear the counter.
- WAIT:
  - On dmem_rvalid: byte = (rdata >> 8·a[1:0]) & 0xFF; half = (rdata >> 16·a[1]) & 0xFFFF; word = rdata.
  - Register the result to wb_data, set wb_valid = 1, go to IDLE.
  - Counter increments each cycle without rvalid. On reaching TIMEOUT_CYCLES: wb_valid = 1, wb_busErr = 1, wb_data = 0, wb_regWrite = 0, go to IDLE.
  - rvalid on the timeout cycle wins over the timeout.
- stall = (state != IDLE) OR (IDLE and accepting an aligned memory op). In the completion cycle stall is still 1; it falls the cycle after.
- wb_* are registered and hold for exactly 1 cycle (wb_valid is a pulse per instruction).
- flush:
  - In IDLE: the incoming op is dropped (no request, wb_valid = 0).
  - In REQ without gnt that cycle: request dropped, go to IDLE, no wb_valid.
  - In REQ with gnt the same cycle: the transaction proceeds, but the discard flag is set.
  - In WAIT: set the discard flag. Keep waiting for rvalid or timeout, then return to IDLE with wb_valid = 0.
- rvalid while in IDLE or REQ is ignored.
- Reset mid-transaction: returns to IDLE immediately. A later stray rvalid is ignored.

Decomposition:
- Shared package mem_pkg holds:
  - localparams for the 8 aluSelect encodings;
  - state encoding (IDLE/REQ/WAIT);
  - helper functions is_load, is_store, access_size.
- Natural sub-module: mem_lane_align. It is combinational and produces be/wdata for stores and the extracted load word. It is reused by both the request and response paths.

Test Plan:
1. LW at 0x100, gnt same cycle as req, rvalid +1 cycle with 0xDEADBEEF -> wb_valid 3 cycles after acceptance, wb_data 0xDEADBEEF, stall high for exactly 3 cycles.
2. LB at 0x103, rdata 0xAABBCCDD -> wb_data 0x000000AA. LHU at 0x102, same data -> wb_data 0x0000AABB, wb_aluSelect 001111.
3. SH at 0x201, data 0x1234 -> no dmem_req; wb_misaligned = 1, wb_regWrite = 0, stall never asserted. SB at 0x202, data 0x5A -> dmem_be 0100, dmem_wdata 0x5A5A5A5A, addr 0x200.
4. Load with gnt delayed 4 cycles, rvalid never -> req stable 5 cycles; after TIMEOUT_CYCLES (set to 8) in WAIT, wb_busErr = 1, wb_data 0, back to IDLE.
5. flush in WAIT, then rvalid 2 cycles later -> wb_valid stays 0, next op accepted normally. flush in REQ before gnt -> dmem_req drops the next cycle.
6. reset asserted in WAIT, rvalid arrives the cycle after reset deasserts -> all outputs 0, rvalid ignored, state IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings, FSM states and access-size helpers for the memory-stage load/store unit.
package mem_pkg;

   localparam logic [5:0] OP_LB  = 6'b001011;
   localparam logic [5:0] OP_LH  = 6'b001100;
   localparam logic [5:0] OP_LW  = 6'b001101;
   localparam logic [5:0] OP_LBU = 6'b001110;
   localparam logic [5:0] OP_LHU = 6'b001111;
   localparam logic [5:0] OP_SB  = 6'b010000;
   localparam logic [5:0] OP_SH  = 6'b010001;
   localparam logic [5:0] OP_SW  = 6'b010010;

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;
   typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_t;

   function automatic logic is_load(input logic [5:0] sel);
      return sel inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
   endfunction

   function automatic logic is_store(input logic [5:0] sel);
      return sel inside {OP_SB, OP_SH, OP_SW};
   endfunction

   function automatic size_t access_size(input logic [5:0] sel);
      case (sel)
         OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
         OP_LH, OP_LHU, OP_SH: return SZ_HALF;
         default:              return SZ_WORD;
      endcase
   endfunction

   function automatic logic is_misaligned(input size_t sz, input logic [1:0] lo);
      return ((sz == SZ_HALF) && lo[0]) || ((sz == SZ_WORD) && (lo != 2'b00));
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables / replicated data and right-aligned load extraction.
// Purely combinational (0 cycles); no backpressure of its own.
module mem_lane_align
   import mem_pkg::*;
(
   input  size_t       size,
   input  logic [1:0]  addrLo,
   input  logic        isStore,
   input  logic [31:0] storeData,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] loadData
);

   always_comb begin
      be       = 4'b1111;
      wdata    = storeData;
      loadData = rdata;
      case (size)
         SZ_BYTE: begin
            be       = 4'b0001 << addrLo;
            wdata    = {4{storeData[7:0]}};
            loadData = (rdata >> {addrLo, 3'b000}) & 32'h0000_00FF;
         end
         SZ_HALF: begin
            be       = 4'b0011 << addrLo;
            wdata    = {2{storeData[15:0]}};
            loadData = (rdata >> {addrLo[1], 4'b0000}) & 32'h0000_FFFF;
         end
         default: ;
      endcase
      // Loads always fetch the whole word; extraction happens on the way back.
      if (!isStore) be = 4'b1111;
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues req/gnt/rvalid transactions and registers the writeback slot.
// Latency 1 cycle for non-memory/faulting ops, 2+ for stores, 3+ for loads; stalls the pipe while busy.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int ADDR_W         = 32
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   input  logic              in_memRead,
   input  logic              in_memWrite,
   input  logic [5:0]        in_aluSelect,
   input  logic [ADDR_W-1:0] in_address,
   input  logic [31:0]       in_storeData,
   input  logic [4:0]        in_rd,
   input  logic              in_regWrite,
   output logic              stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   output logic [3:0]        dmem_be,
   input  logic              dmem_gnt,
   input  logic              dmem_rvalid,
   input  logic [31:0]       dmem_rdata,
   output logic              wb_valid,
   output logic [31:0]       wb_data,
   output logic [4:0]        wb_rd,
   output logic              wb_regWrite,
   output logic [5:0]        wb_aluSelect,
   output logic              wb_misaligned,
   output logic              wb_busErr
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state, stateNext;
   logic [5:0]        opReg;
   logic [ADDR_W-1:0] addrReg;
   logic [4:0]        rdReg;
   logic              regWriteReg, weReg, discard;
   logic [3:0]        beReg;
   logic [31:0]       wdataReg;
   logic [CNT_W-1:0]  count;

   logic        isMem, inMis, accept, storeDone, loadDone, timeOut, cntClr, cntInc, discardSet, kill;
   size_t       inSize, laneSize;
   logic [1:0]  laneLo;
   logic [3:0]  laneBe;
   logic [31:0] laneWdata, laneLoad;

   assign isMem  = in_memRead | in_memWrite;
   assign inSize = access_size(in_aluSelect);
   assign inMis  = is_misaligned(inSize, in_address[1:0]);

   // One aligner serves the request path in IDLE and the response path afterwards.
   assign laneSize = (state == IDLE) ? inSize : access_size(opReg);
   assign laneLo   = (state == IDLE) ? in_address[1:0] : addrReg[1:0];

   mem_lane_align u_align (
      .size      (laneSize),
      .addrLo    (laneLo),
      .isStore   (in_memWrite),
      .storeData (in_storeData),
      .rdata     (dmem_rdata),
      .be        (laneBe),
      .wdata     (laneWdata),
      .loadData  (laneLoad)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext  = state;
      stall      = (state != IDLE);
      accept     = 1'b0;
      storeDone  = 1'b0;
      loadDone   = 1'b0;
      timeOut    = 1'b0;
      cntClr     = 1'b0;
      cntInc     = 1'b0;
      discardSet = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid && !flush && isMem && !inMis) begin
               accept    = 1'b1;
               stall     = 1'b1;
               stateNext = REQ;
            end
         end
         REQ: begin
            if (dmem_gnt) begin
               discardSet = flush;
               if (weReg) begin
                  storeDone = 1'b1;
                  stateNext = IDLE;
               end else begin
                  cntClr    = 1'b1;
                  stateNext = WAIT;
               end
            end else if (flush) begin
               stateNext = IDLE;
            end
         end
         WAIT: begin
            discardSet = flush;
            if (dmem_rvalid) begin
               loadDone  = 1'b1;
               stateNext = IDLE;
            end else if (count == CNT_LAST) begin
               timeOut   = 1'b1;
               stateNext = IDLE;
            end else begin
               cntInc = 1'b1;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // A flush seen during or before completion suppresses the writeback of that op.
   assign kill = discard | discardSet;

   always_ff @(posedge clk) begin
      if (reset) begin
         opReg <= '0; addrReg <= '0; rdReg <= '0; regWriteReg <= 1'b0; weReg <= 1'b0;
         beReg <= '0; wdataReg <= '0; count <= '0; discard <= 1'b0;
         wb_valid <= 1'b0; wb_data <= '0; wb_rd <= '0; wb_regWrite <= 1'b0;
         wb_aluSelect <= '0; wb_misaligned <= 1'b0; wb_busErr <= 1'b0;
      end else begin
         wb_valid <= 1'b0; wb_data <= '0; wb_rd <= '0; wb_regWrite <= 1'b0;
         wb_aluSelect <= '0; wb_misaligned <= 1'b0; wb_busErr <= 1'b0;

         if (state == IDLE && in_valid && !flush) begin
            if (!isMem || inMis) begin
               wb_valid      <= 1'b1;
               wb_data       <= 32'(in_address);
               wb_rd         <= in_rd;
               wb_aluSelect  <= in_aluSelect;
               wb_regWrite   <= !isMem && in_regWrite;
               wb_misaligned <= isMem;
            end
         end
         if (accept) begin
            opReg       <= in_aluSelect;
            addrReg     <= in_address;
            rdReg       <= in_rd;
            regWriteReg <= in_regWrite;
            weReg       <= in_memWrite;
            beReg       <= laneBe;
            wdataReg    <= laneWdata;
         end
         if ((storeDone || loadDone || timeOut) && !kill) begin
            wb_valid     <= 1'b1;
            wb_rd        <= rdReg;
            wb_aluSelect <= opReg;
            wb_regWrite  <= regWriteReg && !timeOut;
            wb_busErr    <= timeOut;
            wb_data      <= loadDone ? laneLoad : (storeDone ? 32'(addrReg) : 32'h0);
         end

         if (cntClr)      count <= '0;
         else if (cntInc) count <= count + 1'b1;

         if (stateNext == IDLE) discard <= 1'b0;
         else if (discardSet)   discard <= 1'b1;
      end
   end

   assign dmem_req   = (state == REQ);
   assign dmem_we    = dmem_req & weReg;
   assign dmem_addr  = dmem_req ? {addrReg[ADDR_W-1:2], 2'b00} : '0;
   assign dmem_be    = dmem_req ? beReg : 4'b0000;
   assign dmem_wdata = dmem_req ? wdataReg : 32'h0;

endmodule
